// File: rtl/cpc_io_write_snooper.sv
// CPC gate-array RAM-config write snooper: glitch-filtered capture of OUT &7Fxx,&Cx.
// Define ROMSEL_SNOOP_EN to also snoop &DFxx upper ROM select writes.
module cpc_io_write_snooper #(
  parameter int unsigned MIN_ASSERT    = 2,
  parameter logic [5:0]  CFG_RESET_VAL = 6'h00
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       A15,
  input  logic       A13,
  input  logic [7:0] D,
  input  logic       IOREQ_B,
  input  logic       WR_B,
  input  logic       M1_B,
  output logic [5:0] ramcfg,
  output logic       cfg_wr,
  output logic       busy,
  output logic [7:0] romsel,
  output logic       romsel_wr
);

  if (MIN_ASSERT < 1 || MIN_ASSERT > 7) begin : g_bad_min
    $error("MIN_ASSERT must be in 1..7");
  end

  localparam logic [2:0] MinC = 3'(MIN_ASSERT);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    CAPTURE,
    WAIT_END
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, cnt_inc;
  logic [7:0]  cap_q, cap_d;
  logic [5:0]  ramcfg_q, ramcfg_d;
  logic        cfg_wr_q, cfg_wr_d;
  logic        busy_q;

  logic qual_io, hit_ram, hit, tgt_hit;

  assign qual_io = ~IOREQ_B & ~WR_B & M1_B;
  assign hit_ram = qual_io & ~A15 & D[7] & D[6];
  assign cnt_inc = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

`ifdef ROMSEL_SNOOP_EN
  logic       hit_rom;
  logic       tgt_q, tgt_d;
  logic [7:0] romsel_q, romsel_d;
  logic       romsel_wr_q, romsel_wr_d;

  assign hit_rom = qual_io & ~A13;
  assign hit     = hit_ram | hit_rom;
  assign tgt_hit = tgt_q ? hit_rom : hit_ram;
`else
  logic unused_ok;

  assign unused_ok = ^{A13, cap_q[7:6]};
  assign hit       = hit_ram;
  assign tgt_hit   = hit_ram;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    ramcfg_d = ramcfg_q;
    cfg_wr_d = 1'b0;
`ifdef ROMSEL_SNOOP_EN
    tgt_d       = tgt_q;
    romsel_d    = romsel_q;
    romsel_wr_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          cnt_d   = 3'd1;
          cap_d   = D;
          state_d = (MinC == 3'd1) ? CAPTURE : QUAL;
`ifdef ROMSEL_SNOOP_EN
          // RAM decode wins when both match
          tgt_d   = ~hit_ram;
`endif
        end
      end
      QUAL: begin
        if (tgt_hit) begin
          cnt_d = cnt_inc;
          cap_d = D;
          if (cnt_inc == MinC) state_d = CAPTURE;
        end else begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        cnt_d   = 3'd0;
        state_d = WAIT_END;
`ifdef ROMSEL_SNOOP_EN
        if (tgt_q) begin
          romsel_d    = cap_q;
          romsel_wr_d = 1'b1;
        end else begin
          ramcfg_d = cap_q[5:0];
          cfg_wr_d = 1'b1;
        end
`else
        ramcfg_d = cap_q[5:0];
        cfg_wr_d = 1'b1;
`endif
      end
      WAIT_END: begin
        if (!qual_io) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      cap_q    <= 8'h00;
      ramcfg_q <= CFG_RESET_VAL;
      cfg_wr_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      ramcfg_q <= ramcfg_d;
      cfg_wr_q <= cfg_wr_d;
      busy_q   <= (state_d != IDLE);
    end
  end

`ifdef ROMSEL_SNOOP_EN
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      tgt_q       <= 1'b0;
      romsel_q    <= 8'h00;
      romsel_wr_q <= 1'b0;
    end else begin
      tgt_q       <= tgt_d;
      romsel_q    <= romsel_d;
      romsel_wr_q <= romsel_wr_d;
    end
  end

  assign romsel    = romsel_q;
  assign romsel_wr = romsel_wr_q;
`else
  assign romsel    = 8'h00;
  assign romsel_wr = 1'b0;
`endif

  assign ramcfg = ramcfg_q;
  assign cfg_wr = cfg_wr_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_cpc_io_write_snooper.sv
// Bench for cpc_io_write_snooper: directed + random bus traffic vs a
// run-length reference model of the qualification rules.
`timescale 1ns/1ps
module tb_cpc_io_write_snooper;

  localparam int         M  = 2;
  localparam logic [5:0] RV = 6'h00;
  localparam int         N  = 2000;
`ifdef ROMSEL_SNOOP_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a15, a13, io_b, wr_b, m1_b;
  logic [7:0] d;
  logic [5:0] ramcfg;
  logic       cfg_wr, busy, romsel_wr;
  logic [7:0] romsel;

  always #5 clk = ~clk;

  cpc_io_write_snooper #(
    .MIN_ASSERT   (M),
    .CFG_RESET_VAL(RV)
  ) u_dut (
    .CLK      (clk),
    .RESET_B  (rst_n),
    .A15      (a15),
    .A13      (a13),
    .D        (d),
    .IOREQ_B  (io_b),
    .WR_B     (wr_b),
    .M1_B     (m1_b),
    .ramcfg   (ramcfg),
    .cfg_wr   (cfg_wr),
    .busy     (busy),
    .romsel   (romsel),
    .romsel_wr(romsel_wr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic       s_a15[N], s_a13[N], s_io[N], s_wr[N], s_m1[N];
  logic [7:0] s_d[N];
  int         ns = 0;

  logic [5:0] e_ram[N];
  logic [7:0] e_rom[N];
  logic       e_wr[N], e_rwr[N], e_busy[N];

  task automatic push(input logic a15_, input logic a13_,
                      input logic [7:0] d_, input logic io_,
                      input logic wr_, input logic m1_, input int len);
    for (int i = 0; i < len; i++) begin
      if (ns < N) begin
        s_a15[ns] = a15_; s_a13[ns] = a13_; s_d[ns] = d_;
        s_io[ns] = io_; s_wr[ns] = wr_; s_m1[ns] = m1_;
        ns++;
      end
    end
  endtask

  task automatic idle(input int len);
    push(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b1, 1'b1, len);
  endtask

  // Scan the sample stream: a run of >= M target-decode samples starting
  // while ready captures the data of its M-th sample.
  task automatic build_expect();
    bit         q[N], hr[N], hm[N], u_ram[N], u_rom[N];
    logic [7:0] v[N];
    int k, s, r, p, e;
    bit rom;
    logic [5:0] cr;
    logic [7:0] co;
    for (int i = 0; i < ns; i++) begin
      q[i]  = !s_io[i] && !s_wr[i] && s_m1[i];
      hr[i] = q[i] && !s_a15[i] && s_d[i][7] && s_d[i][6];
      hm[i] = FEAT && q[i] && !s_a13[i];
      u_ram[i] = 0; u_rom[i] = 0; v[i] = 8'h00; e_busy[i] = 1'b0;
    end
    k = 0;
    while (k < ns) begin
      if (!(hr[k] || hm[k])) begin
        k++;
      end else begin
        s = k;
        rom = !hr[s];
        r = 0;
        while (s + r < ns && (rom ? hm[s+r] : hr[s+r])) r++;
        if (r >= M) begin
          p = s + M;
          if (p < ns) begin
            if (rom) u_rom[p] = 1; else u_ram[p] = 1;
            v[p] = s_d[p-1];
          end
          e = p + 1;
          while (e < ns && q[e]) e++;
          for (int j = s; j < e && j < ns; j++) e_busy[j] = 1'b1;
          k = e;
        end else begin
          for (int j = s; j < s + r; j++) e_busy[j] = 1'b1;
          k = s + r;
        end
      end
    end
    cr = RV;
    co = 8'h00;
    for (int i = 0; i < ns; i++) begin
      if (u_ram[i]) cr = v[i][5:0];
      if (u_rom[i]) co = v[i];
      e_ram[i] = cr; e_rom[i] = co;
      e_wr[i] = u_ram[i]; e_rwr[i] = u_rom[i];
    end
  endtask

  task automatic gen_random(input int count);
    int kind, len, gap;
    logic [7:0] dv;
    for (int t = 0; t < count; t++) begin
      kind = int'($urandom_range(0, 4));
      len  = int'($urandom_range(1, 6));
      gap  = int'($urandom_range(0, 3));
      dv   = 8'($urandom);
      unique case (kind)
        0: push(1'b0, 1'($urandom), {2'b11, dv[5:0]}, 1'b0, 1'b0, 1'b1, len);
        1: push(1'b1, 1'($urandom), dv, 1'b0, 1'b0, 1'b1, len);
        2: push(1'b0, 1'b1, {1'b0, dv[6:0]}, 1'b0, 1'b0, 1'b1, len);
        3: push(1'b0, 1'($urandom), {2'b11, dv[5:0]}, 1'b0, 1'b0, 1'b0, len);
        default: push(1'b0, 1'b1, {2'b11, dv[5:0]}, 1'b0, 1'b1, 1'b1, len);
      endcase
      idle(gap);
    end
  endtask

  task automatic drive(input int k);
    a15 = s_a15[k]; a13 = s_a13[k]; d = s_d[k];
    io_b = s_io[k]; wr_b = s_wr[k]; m1_b = s_m1[k];
  endtask

  initial begin
    rst_n = 1'b0;
    a15 = 1'b1; a13 = 1'b1; d = 8'h00;
    io_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;

    idle(2);
    push(1'b0, 1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 3);
    idle(2);
    push(1'b0, 1'b1, 8'hC7, 1'b0, 1'b0, 1'b1, 1);
    idle(2);
    push(1'b1, 1'b1, 8'hC7, 1'b0, 1'b0, 1'b1, 3);
    idle(2);
    push(1'b0, 1'b1, 8'h8F, 1'b0, 1'b0, 1'b1, 3);
    idle(2);
    push(1'b0, 1'b1, 8'hC7, 1'b0, 1'b0, 1'b0, 3);
    idle(2);
    push(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 10);
    idle(1);
    push(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 3);
    idle(2);
    push(1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 3);
    idle(2);
    gen_random(250);
    idle(10);
    build_expect();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ramcfg", 8'(ramcfg), 8'(RV));
    chk("rst_cfg_wr", 8'(cfg_wr), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_romsel", romsel, 8'h00);
    chk("rst_romsel_wr", 8'(romsel_wr), 8'h00);
    rst_n = 1'b1;

    for (int k = 0; k < ns; k++) begin
      drive(k);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ramcfg@%0d", k), 8'(ramcfg), 8'(e_ram[k]));
      chk($sformatf("cfg_wr@%0d", k), 8'(cfg_wr), 8'(e_wr[k]));
      chk($sformatf("busy@%0d", k), 8'(busy), 8'(e_busy[k]));
      chk($sformatf("romsel@%0d", k), romsel, e_rom[k]);
      chk($sformatf("romsel_wr@%0d", k), 8'(romsel_wr), 8'(e_rwr[k]));
    end

    a15 = 1'b0; a13 = 1'b1; d = 8'hC5;
    io_b = 1'b0; wr_b = 1'b0; m1_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_cfg_wr", 8'(cfg_wr), 8'h01);
    chk("pre_rst_ramcfg", 8'(ramcfg), 8'h05);
    #1 rst_n = 1'b0;
    #1;
    chk("async_cfg_wr", 8'(cfg_wr), 8'h00);
    chk("async_busy", 8'(busy), 8'h00);
    chk("async_ramcfg", 8'(ramcfg), 8'(RV));
    chk("async_romsel", romsel, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpc_io_write_snooper.md
Name: cpc_io_write_snooper

Overview:
- Clocked Z80 bus snooper that sits upstream of the RAM bank/high-address register stage.
- Qualifies CPC I/O write cycles to the gate-array port (&7Fxx, data D7:D6=11) and emits a one-cycle update strobe plus the captured configuration byte.
- Replaces the asynchronous NOR/NAND/latch clock-enable path with a glitch-filtered, M1-aware state machine suitable for CPLD integration.

Parameters:
- MIN_ASSERT, 2, consecutive CLK samples (1..7) of a valid qualified write required before capture.
- CFG_RESET_VAL, 6'h00, value of ramcfg after reset.

Ports:
- CLK  input  1  CPC 4 MHz bus clock; all sampling on rising edge.
- RESET_B  input  1  asynchronous active-low reset.
- A15  input  1  Z80 address bit 15.
- A13  input  1  Z80 address bit 13; used only with ROMSEL_SNOOP_EN.
- D  input  8  Z80 data bus D7..D0.
- IOREQ_B  input  1  Z80 I/O request, active low.
- WR_B  input  1  Z80 write strobe, active low.
- M1_B  input  1  Z80 M1, active low; IOREQ_B with M1_B low is interrupt acknowledge.
- ramcfg  output  6  registered RAM config: [2:0]=ramblock, [5:3]=hiadr bits 2..4.
- cfg_wr  output  1  one-cycle pulse when ramcfg is updated.
- busy  output  1  high while the FSM is not in IDLE.
- romsel  output  8  upper ROM select; real only with ROMSEL_SNOOP_EN.
- romsel_wr  output  1  one-cycle pulse on romsel update; only with ROMSEL_SNOOP_EN.

Behaviour:
- Reset (async, RESET_B low): state=IDLE, count=0, ramcfg=CFG_RESET_VAL, cfg_wr=0, busy=0, romsel=8'h00, romsel_wr=0. Applies immediately, even mid-cycle or during a strobe.
- qual_io = !IOREQ_B & !WR_B & M1_B.
- hit_ram = qual_io & !A15 & D[7] & D[6].
- hit_rom = qual_io & !A13 (feature only).
- hit = hit_ram | hit_rom.
- The target latched on entry to QUAL: RAM has priority when both decodes are true.
- State IDLE:
  - hit -> QUAL, count=1, target latched.
  - If MIN_ASSERT=1, go directly to CAPTURE instead.
- State QUAL:
  - On each sample where the latched target's decode is still true, count++.
  - When count==MIN_ASSERT -> CAPTURE.
  - Decode false on any sample -> IDLE with no strobe (glitch rejected).
- State CAPTURE, exactly one cycle:
  - ramcfg<=D[5:0] (or romsel<=D[7:0]), sampled on the qualifying edge that caused entry.
  - cfg_wr (or romsel_wr)=1 for this one cycle.
  - Next state is always WAIT_END.
- State WAIT_END:
  - Holds until !qual_io is sampled, i.e. IOREQ_B or WR_B high, or M1_B low; then -> IDLE.
  - Guarantees at most one capture per bus cycle, however long the cycle.
- Latency: capture visible on the output MIN_ASSERT+1 rising edges after the first hit sample.
- Strobes: cfg_wr and romsel_wr are registered outputs, never both high, never high for two consecutive cycles.
- busy = (state != IDLE), registered.
- Back-to-back OUTs: a new hit is accepted the cycle after WAIT_END returns to IDLE. A hit sampled in that IDLE cycle is honoured.
- Non-matching writes are ignored and ramcfg is held. Examples: A15=1, D7:D6 != 11, or M1_B low.
- Count width is 3 bits and saturates at 7. MIN_ASSERT outside 1..7 is a synthesis error.

Optional Feature:
- Macro: ROMSEL_SNOOP_EN.
- Defined: writes with A13=0 (&DFxx upper ROM select) are also qualified through the same FSM; romsel/romsel_wr are live. An OUT with A15=0, A13=0, D7:D6=11 updates ramcfg only.
- Undefined: romsel is tied to 8'h00, romsel_wr is tied to 0, and A13 is ignored. The FSM encoding has no ROM target.

Test Plan:
- Reset, then OUT &7F00,&C4 with IOREQ_B/WR_B low for 3 cycles, MIN_ASSERT=2 -> ramcfg=6'h04 and a single cfg_wr pulse 3 edges after the first low sample; busy is high until IOREQ_B rises.
- 1-cycle glitch: IOREQ_B/WR_B low for one sample with D=&C7, A15=0 -> no cfg_wr and ramcfg unchanged.
- Non-target writes: OUT &BC00,&C7 (A15=1), OUT &7F00,&8F (D7:D6=10), and an interrupt ack (M1_B=0, IOREQ_B=0, WR_B=0) -> no strobe, ramcfg held.
- Long cycle and back-to-back: IOREQ_B/WR_B low for 10 cycles with D=&C1 -> exactly one cfg_wr pulse. One idle cycle, then OUT &7F00,&FF -> second pulse, ramcfg=6'h3F.
- Async reset mid-CAPTURE: assert RESET_B low while cfg_wr=1 -> cfg_wr, busy and ramcfg clear (ramcfg=CFG_RESET_VAL) immediately, before the next edge.
- ROMSEL_SNOOP_EN defined: OUT &DF00,&07 -> romsel=8'h07, one romsel_wr pulse, ramcfg unchanged. Undefined: same stimulus -> no strobe, romsel=8'h00.
